// File: rtl/id_stage_pipelined.sv
// MIPS-I subset decode stage: 2R/1W regfile, BEQ/BNE/J resolved in ID, hazard FSM, ID/EX latch.
// Define DU_PORT_EN to add a third, unbypassed debug read port (i_du_raddr/o_du_rdata).
module id_stage_pipelined #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 32,
    parameter int RADDR_W = $clog2(NREGS)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [31:0]        i_instr,
    input  logic [DATA_W-1:0]  i_pc_plus_4,
    input  logic               i_wb_we,
    input  logic [RADDR_W-1:0] i_wb_rd,
    input  logic [DATA_W-1:0]  i_wb_data,
    input  logic               i_exm_reg_write,
    input  logic               i_exm_memtoreg,
    input  logic [RADDR_W-1:0] i_exm_rd,
    input  logic [DATA_W-1:0]  i_exm_alu,
    output logic               o_stall,
    output logic               o_pc_src,
    output logic [DATA_W-1:0]  o_pc_target,
    output logic               o_flush_ifid,
    output logic               o_ex_valid,
    output logic [8:0]         o_ex_ctrl,
    output logic [DATA_W-1:0]  o_ex_rs_data,
    output logic [DATA_W-1:0]  o_ex_rt_data,
    output logic [DATA_W-1:0]  o_ex_imm,
    output logic [RADDR_W-1:0] o_ex_rs,
    output logic [RADDR_W-1:0] o_ex_rt,
    output logic [RADDR_W-1:0] o_ex_rd,
    output logic [5:0]         o_ex_funct,
    output logic               o_halt
`ifdef DU_PORT_EN
    ,
    input  logic [RADDR_W-1:0] i_du_raddr,
    output logic [DATA_W-1:0]  o_du_rdata
`endif
);

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_J = 6'h02, OP_HALT = 6'h3F;
    // ctrl = {reg_write, mem_read, mem_write, memtoreg, alu_src, alu_op[3:0]}
    localparam logic [8:0] C_R = 9'h102, C_LW = 9'h1B0, C_SW = 9'h050, C_BR = 9'h001, C_ADDI = 9'h110;

    localparam logic [1:0] S_RUN = 2'd0, S_STALL1 = 2'd1, S_STALL2 = 2'd2, S_HALTED = 2'd3;

    typedef struct packed {
        logic               valid;
        logic [8:0]         ctrl;
        logic [DATA_W-1:0]  rs_data;
        logic [DATA_W-1:0]  rt_data;
        logic [DATA_W-1:0]  imm;
        logic [RADDR_W-1:0] rs;
        logic [RADDR_W-1:0] rt;
        logic [RADDR_W-1:0] rd;
        logic [5:0]         funct;
    } idex_t;

    idex_t             idex_q, idex_d;
    logic [1:0]        state_q, state_d;
    logic              halt_q, halt_d;
    logic [DATA_W-1:0] rf_q [NREGS];

    logic [5:0]         op;
    logic [RADDR_W-1:0] rs, rt, rdf, dest;
    logic [DATA_W-1:0]  imm_sext, rs_rf, rt_rf, rs_br, rt_br;
    logic [8:0]         ctrl;
    logic               use_rs, use_rt, is_beq, is_bne, is_j, is_halt, is_br;
    logic               ex_ld, ex_alu_w, exm_fwd, exm_ld, hit_ex, hit_exm;
    logic               need1, need2, stall, issue, taken;

    assign op       = i_instr[31:26];
    assign rs       = i_instr[21 +: RADDR_W];
    assign rt       = i_instr[16 +: RADDR_W];
    assign rdf      = i_instr[11 +: RADDR_W];
    assign imm_sext = {{(DATA_W-16){i_instr[15]}}, i_instr[15:0]};

    always_comb begin
        ctrl    = '0;
        dest    = '0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_j    = 1'b0;
        is_halt = 1'b0;
        case (op)
            OP_R:    begin ctrl = C_R;    dest = rdf; use_rs = 1'b1; use_rt = 1'b1; end
            OP_LW:   begin ctrl = C_LW;   dest = rt;  use_rs = 1'b1; end
            OP_SW:   begin ctrl = C_SW;   use_rs = 1'b1; use_rt = 1'b1; end
            OP_BEQ:  begin ctrl = C_BR;   use_rs = 1'b1; use_rt = 1'b1; is_beq = 1'b1; end
            OP_BNE:  begin ctrl = C_BR;   use_rs = 1'b1; use_rt = 1'b1; is_bne = 1'b1; end
            OP_ADDI: begin ctrl = C_ADDI; dest = rt;  use_rs = 1'b1; end
            OP_J:    is_j = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

    // Write-through: a same-cycle writeback is visible to the decoding instruction.
    assign rs_rf = (rs == '0) ? '0 : (i_wb_we && i_wb_rd == rs) ? i_wb_data : rf_q[rs];
    assign rt_rf = (rt == '0) ? '0 : (i_wb_we && i_wb_rd == rt) ? i_wb_data : rf_q[rt];

    assign exm_fwd = i_exm_reg_write && !i_exm_memtoreg && i_exm_rd != '0;
    assign exm_ld  = i_exm_reg_write && i_exm_memtoreg && i_exm_rd != '0;
    assign rs_br   = (exm_fwd && i_exm_rd == rs) ? i_exm_alu : rs_rf;
    assign rt_br   = (exm_fwd && i_exm_rd == rt) ? i_exm_alu : rt_rf;

    assign ex_ld    = idex_q.ctrl[7] && idex_q.rd != '0;
    assign ex_alu_w = idex_q.ctrl[8] && !idex_q.ctrl[7] && idex_q.rd != '0;
    assign hit_ex   = (use_rs && rs == idex_q.rd) || (use_rt && rt == idex_q.rd);
    assign hit_exm  = (use_rs && rs == i_exm_rd) || (use_rt && rt == i_exm_rd);
    assign is_br    = is_beq || is_bne;

    // A branch behind an ID/EX load needs the load to reach writeback: two bubbles.
    assign need2 = is_br && ex_ld && hit_ex;
    assign need1 = (ex_ld && hit_ex) || (is_br && ex_alu_w && hit_ex) || (is_br && exm_ld && hit_exm);

    assign stall = (state_q == S_RUN && i_valid && (need1 || need2)) ||
                   state_q == S_STALL2 || state_q == S_HALTED;
    assign issue = i_valid && !stall;
    assign taken = is_j || (is_beq && rs_br == rt_br) || (is_bne && rs_br != rt_br);

    assign o_stall      = stall;
    assign o_pc_src     = issue && taken;
    assign o_flush_ifid = o_pc_src;
    assign o_pc_target  = is_j ? {i_pc_plus_4[DATA_W-1:28], i_instr[25:0], 2'b00}
                               : i_pc_plus_4 + (imm_sext << 2);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (i_valid && need2)        state_d = S_STALL2;
                else if (i_valid && need1)   state_d = S_STALL1;
                else if (issue && is_halt)   state_d = S_HALTED;
            end
            S_STALL2: state_d = S_STALL1;
            S_STALL1: state_d = (issue && is_halt) ? S_HALTED : S_RUN;
            default:  state_d = S_HALTED;
        endcase
    end

    // Stalled or empty cycles insert a bubble: valid/ctrl cleared, payload held.
    always_comb begin
        idex_d       = idex_q;
        idex_d.valid = 1'b0;
        idex_d.ctrl  = '0;
        if (issue) begin
            idex_d.valid   = 1'b1;
            idex_d.ctrl    = ctrl;
            idex_d.rs_data = rs_rf;
            idex_d.rt_data = rt_rf;
            idex_d.imm     = imm_sext;
            idex_d.rs      = rs;
            idex_d.rt      = rt;
            idex_d.rd      = dest;
            idex_d.funct   = i_instr[5:0];
        end
        halt_d = halt_q || (issue && is_halt);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            idex_q  <= '0;
            state_q <= S_RUN;
            halt_q  <= 1'b0;
        end else begin
            idex_q  <= idex_d;
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (i_wb_we && i_wb_rd != '0) begin
            rf_q[i_wb_rd] <= i_wb_data;
        end
    end

`ifdef DU_PORT_EN
    assign o_du_rdata = rf_q[i_du_raddr];
`endif

    assign o_ex_valid   = idex_q.valid;
    assign o_ex_ctrl    = idex_q.ctrl;
    assign o_ex_rs_data = idex_q.rs_data;
    assign o_ex_rt_data = idex_q.rt_data;
    assign o_ex_imm     = idex_q.imm;
    assign o_ex_rs      = idex_q.rs;
    assign o_ex_rt      = idex_q.rt;
    assign o_ex_rd      = idex_q.rd;
    assign o_ex_funct   = idex_q.funct;
    assign o_halt       = halt_q;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed vector bench for id_stage_pipelined: a cycle-by-cycle table plus reset/regfile sequences.
module tb_id_stage_pipelined;

    logic        i_clk = 1'b0;
    logic        i_reset, i_valid, i_wb_we, i_exm_reg_write, i_exm_memtoreg;
    logic [31:0] i_instr, i_pc_plus_4, i_wb_data, i_exm_alu;
    logic [4:0]  i_wb_rd, i_exm_rd;
    logic        o_stall, o_pc_src, o_flush_ifid, o_ex_valid, o_halt;
    logic [31:0] o_pc_target, o_ex_rs_data, o_ex_rt_data, o_ex_imm;
    logic [8:0]  o_ex_ctrl;
    logic [4:0]  o_ex_rs, o_ex_rt, o_ex_rd;
    logic [5:0]  o_ex_funct;
`ifdef DU_PORT_EN
    logic [4:0]  i_du_raddr = '0;
    logic [31:0] o_du_rdata;
`endif

    id_stage_pipelined dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_instr(i_instr),
        .i_pc_plus_4(i_pc_plus_4), .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .i_exm_reg_write(i_exm_reg_write), .i_exm_memtoreg(i_exm_memtoreg),
        .i_exm_rd(i_exm_rd), .i_exm_alu(i_exm_alu),
        .o_stall(o_stall), .o_pc_src(o_pc_src), .o_pc_target(o_pc_target),
        .o_flush_ifid(o_flush_ifid), .o_ex_valid(o_ex_valid), .o_ex_ctrl(o_ex_ctrl),
        .o_ex_rs_data(o_ex_rs_data), .o_ex_rt_data(o_ex_rt_data), .o_ex_imm(o_ex_imm),
        .o_ex_rs(o_ex_rs), .o_ex_rt(o_ex_rt), .o_ex_rd(o_ex_rd), .o_ex_funct(o_ex_funct),
`ifdef DU_PORT_EN
        .i_du_raddr(i_du_raddr), .o_du_rdata(o_du_rdata),
`endif
        .o_halt(o_halt)
    );

    always #5 i_clk = ~i_clk;

    localparam logic [8:0] C_R = 9'h102, C_LW = 9'h1B0, C_SW = 9'h050, C_BR = 9'h001, C_ADDI = 9'h110;

    typedef struct {
        logic        vld;
        logic [31:0] ins, pc4;
        logic        wbwe;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic [1:0]  exm;      // {reg_write, memtoreg}
        logic [4:0]  exmrd;
        logic [31:0] exmalu;
        logic        st, ps;
        logic [31:0] tgt;
        logic        ev;
        logic [8:0]  ctl;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  rd;
        logic        hlt;
    } vec_t;

    int n_vec = 0, n_cmp = 0, n_err = 0;
    vec_t vq[$];

    function automatic logic [31:0] R(input logic [4:0] rs, rt, rd);
        return {6'h00, rs, rt, rd, 5'h00, 6'h20};
    endfunction
    function automatic logic [31:0] I(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] J(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    function automatic vec_t V(input logic vld, input logic [31:0] ins, pc4, input logic wbwe,
                               input logic [4:0] wbrd, input logic [31:0] wbd, input logic [1:0] exm,
                               input logic [4:0] exmrd, input logic [31:0] exmalu, input logic st, ps,
                               input logic [31:0] tgt, input logic ev, input logic [8:0] ctl,
                               input logic [31:0] rsd, rtd, imm, input logic [4:0] rd, input logic hlt);
        vec_t v;
        v.vld = vld; v.ins = ins; v.pc4 = pc4; v.wbwe = wbwe; v.wbrd = wbrd; v.wbd = wbd;
        v.exm = exm; v.exmrd = exmrd; v.exmalu = exmalu; v.st = st; v.ps = ps; v.tgt = tgt;
        v.ev = ev; v.ctl = ctl; v.rsd = rsd; v.rtd = rtd; v.imm = imm; v.rd = rd; v.hlt = hlt;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [31:0] ins, pc4, input logic wbwe,
                         input logic [4:0] wbrd, input logic [31:0] wbd, input logic [1:0] exm,
                         input logic [4:0] exmrd, input logic [31:0] exmalu);
        i_valid = vld; i_instr = ins; i_pc_plus_4 = pc4;
        i_wb_we = wbwe; i_wb_rd = wbrd; i_wb_data = wbd;
        i_exm_reg_write = exm[1]; i_exm_memtoreg = exm[0]; i_exm_rd = exmrd; i_exm_alu = exmalu;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] LW_R2, ADD_R3, LW_R5, BEQ_A, BNE_A, ADDI_6, BEQ_B, ADD_R10, ADD_R11;
        logic [31:0] JMP, NOPX, SW_A, HALT, BEQ_C;
        logic [4:0]  pre_r [4];
        logic [31:0] pre_v [4];
        LW_R2 = I(6'h23, 1, 2, 0);       ADD_R3 = R(2, 4, 3);         LW_R5 = I(6'h23, 1, 5, 4);
        BEQ_A = I(6'h04, 5, 0, 4);       BNE_A = I(6'h05, 6, 7, 16'hFFFE);
        ADDI_6 = I(6'h08, 0, 6, 5);      BEQ_B = I(6'h04, 6, 7, 1);
        ADD_R10 = R(8, 9, 10);           ADD_R11 = R(0, 8, 11);       JMP = J(6'h02, 26'h40);
        NOPX = I(6'h0F, 1, 4, 0);        SW_A = I(6'h2B, 1, 4, 8);    HALT = J(6'h3F, 0);
        BEQ_C = I(6'h04, 0, 0, 1);
        pre_r = '{5'd1, 5'd4, 5'd7, 5'd9};
        pre_v = '{32'h100, 32'h11, 32'h7, 32'h9};

        // load-use: one bubble
        vq.push_back(V(1, LW_R2,  32'h1004, 0, 0, 0,        2'b00, 0, 0,      0, 0, 0,           1, C_LW, 32'h100, 0, 0, 2, 0));
        vq.push_back(V(1, ADD_R3, 32'h1008, 0, 0, 0,        2'b00, 0, 0,      1, 0, 0,           0, 0, 0, 0, 0, 0, 0));
        vq.push_back(V(1, ADD_R3, 32'h1008, 0, 0, 0,        2'b11, 2, 32'h100, 0, 0, 0,          1, C_R, 0, 32'h11, 32'h1820, 3, 0));
        vq.push_back(V(1, LW_R5,  32'h100C, 1, 2, 32'h55,   2'b00, 0, 0,      0, 0, 0,           1, C_LW, 32'h100, 0, 4, 5, 0));
        // branch behind ID/EX load: two bubbles, then taken via WB bypass
        vq.push_back(V(1, BEQ_A,  32'h2000, 0, 0, 0,        2'b10, 3, 32'h66, 1, 0, 0,           0, 0, 0, 0, 0, 0, 0));
        vq.push_back(V(1, BEQ_A,  32'h2000, 0, 0, 0,        2'b11, 5, 0,      1, 0, 0,           0, 0, 0, 0, 0, 0, 0));
        vq.push_back(V(1, BEQ_A,  32'h2000, 1, 5, 0,        2'b00, 0, 0,      0, 1, 32'h2010,    1, C_BR, 0, 0, 4, 0, 0));
        // EX/MEM ALU forwarding into BNE compare
        vq.push_back(V(1, BNE_A,  32'h3000, 0, 0, 0,        2'b10, 6, 7,      0, 0, 0,           1, C_BR, 0, 7, 32'hFFFFFFFE, 0, 0));
        vq.push_back(V(1, BNE_A,  32'h3000, 0, 0, 0,        2'b10, 6, 8,      0, 1, 32'h2FF8,    1, C_BR, 0, 7, 32'hFFFFFFFE, 0, 0));
        // branch vs EX/MEM load: one bubble, no forward from a load
        vq.push_back(V(1, BNE_A,  32'h3000, 0, 0, 0,        2'b11, 6, 8,      1, 0, 0,           0, 0, 0, 0, 0, 0, 0));
        vq.push_back(V(1, BNE_A,  32'h3000, 1, 6, 7,        2'b00, 0, 0,      0, 0, 0,           1, C_BR, 7, 7, 32'hFFFFFFFE, 0, 0));
        // branch vs ID/EX ALU writer: one bubble, then forward makes it not taken
        vq.push_back(V(1, ADDI_6, 32'h3004, 0, 0, 0,        2'b00, 0, 0,      0, 0, 0,           1, C_ADDI, 0, 7, 5, 6, 0));
        vq.push_back(V(1, BEQ_B,  32'h4000, 0, 0, 0,        2'b00, 0, 0,      1, 0, 0,           0, 0, 0, 0, 0, 0, 0));
        vq.push_back(V(1, BEQ_B,  32'h4000, 0, 0, 0,        2'b10, 6, 5,      0, 0, 0,           1, C_BR, 7, 7, 1, 0, 0));
        // writeback bypass and r0
        vq.push_back(V(1, ADD_R10, 32'h4004, 1, 8, 32'hDEAD, 2'b00, 0, 0,     0, 0, 0,           1, C_R, 32'hDEAD, 9, 32'h5020, 10, 0));
        vq.push_back(V(1, ADD_R11, 32'h4008, 1, 0, 32'h1234, 2'b00, 0, 0,     0, 0, 0,           1, C_R, 0, 32'hDEAD, 32'h5820, 11, 0));
        vq.push_back(V(0, ADD_R11, 32'h4008, 0, 0, 0,        2'b00, 0, 0,     0, 0, 0,           0, 0, 0, 0, 0, 0, 0));
        vq.push_back(V(1, JMP,    32'h50000010, 0, 0, 0,    2'b00, 0, 0,      0, 1, 32'h50000100, 1, 0, 0, 0, 32'h40, 0, 0));
        vq.push_back(V(1, NOPX,   32'h5000, 0, 0, 0,        2'b00, 0, 0,      0, 0, 0,           1, 0, 32'h100, 32'h11, 0, 0, 0));
        vq.push_back(V(1, SW_A,   32'h5004, 0, 0, 0,        2'b00, 0, 0,      0, 0, 0,           1, C_SW, 32'h100, 32'h11, 8, 0, 0));
        // HALT: sticky, everything after bubbles
        vq.push_back(V(1, HALT,   32'h5008, 0, 0, 0,        2'b00, 0, 0,      0, 0, 0,           1, 0, 0, 0, 0, 0, 1));
        vq.push_back(V(1, ADD_R3, 32'h500C, 0, 0, 0,        2'b00, 0, 0,      1, 0, 0,           0, 0, 0, 0, 0, 0, 1));
        vq.push_back(V(1, BEQ_C,  32'h5010, 1, 12, 32'h77,  2'b00, 0, 0,      1, 0, 0,           0, 0, 0, 0, 0, 0, 1));

        i_reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        repeat (2) @(negedge i_clk);
        n_vec++;
        chk("rst_ex_valid", 0, o_ex_valid, 0);
        chk("rst_ex_ctrl", 0, o_ex_ctrl, 0);
        chk("rst_ex_rs_data", 0, o_ex_rs_data, 0);
        chk("rst_halt", 0, o_halt, 0);
        chk("rst_stall", 0, o_stall, 0);
        i_reset = 1'b1;

        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            drive(0, 0, 0, 1, pre_r[k], pre_v[k], 2'b00, 0, 0);
        end

        foreach (vq[k]) begin
            @(negedge i_clk);
            drive(vq[k].vld, vq[k].ins, vq[k].pc4, vq[k].wbwe, vq[k].wbrd, vq[k].wbd,
                  vq[k].exm, vq[k].exmrd, vq[k].exmalu);
            n_vec++;
            #1;
            chk("stall", k, o_stall, vq[k].st);
            chk("pc_src", k, o_pc_src, vq[k].ps);
            chk("flush_ifid", k, o_flush_ifid, vq[k].ps);
            if (vq[k].ps) chk("pc_target", k, o_pc_target, vq[k].tgt);
            @(posedge i_clk);
            #1;
            chk("ex_valid", k, o_ex_valid, vq[k].ev);
            chk("ex_ctrl", k, o_ex_ctrl, vq[k].ctl);
            chk("halt", k, o_halt, vq[k].hlt);
            if (vq[k].ev) begin
                chk("ex_rs_data", k, o_ex_rs_data, vq[k].rsd);
                chk("ex_rt_data", k, o_ex_rt_data, vq[k].rtd);
                chk("ex_imm", k, o_ex_imm, vq[k].imm);
                chk("ex_rd", k, o_ex_rd, vq[k].rd);
                chk("ex_rs", k, o_ex_rs, vq[k].ins[25:21]);
                chk("ex_rt", k, o_ex_rt, vq[k].ins[20:16]);
                chk("ex_funct", k, o_ex_funct, vq[k].ins[5:0]);
            end
        end

        // Reset asserted while in STALL2 must clear everything and return to RUN.
        @(negedge i_clk);
        i_reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        drive(0, 0, 0, 1, 1, 32'h100, 2'b00, 0, 0);
        @(negedge i_clk);
        drive(1, LW_R5, 32'h6000, 0, 0, 0, 2'b00, 0, 0);
        @(negedge i_clk);
        drive(1, BEQ_A, 32'h6004, 0, 0, 0, 2'b00, 0, 0);
        n_vec++;
        #1 chk("pre_rst_hazard_stall", 100, o_stall, 1);
        @(negedge i_clk);
        n_vec++;
        #1 chk("stall2_stall", 101, o_stall, 1);
        chk("stall2_ex_rs_data_held", 101, o_ex_rs_data, 32'h100);
        i_reset = 1'b0;
        #1;
        chk("midrst_ex_valid", 102, o_ex_valid, 0);
        chk("midrst_ex_ctrl", 102, o_ex_ctrl, 0);
        chk("midrst_ex_rs_data", 102, o_ex_rs_data, 0);
        chk("midrst_ex_imm", 102, o_ex_imm, 0);
        chk("midrst_ex_rd", 102, o_ex_rd, 0);
        chk("midrst_halt", 102, o_halt, 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        n_vec++;
        #1;
        chk("postrst_stall", 103, o_stall, 0);
        chk("postrst_pc_src", 103, o_pc_src, 1);
        chk("postrst_target", 103, o_pc_target, 32'h6014);
        for (int r = 1; r < 32; r++) begin
            logic [4:0] ra, rb;
            ra = 5'(r);
            rb = (r == 31) ? 5'd1 : 5'(r + 1);
            @(negedge i_clk);
            drive(1, R(ra, rb, 0), 32'h7000, 0, 0, 0, 2'b00, 0, 0);
            n_vec++;
            #1 chk("rf_clr_stall", 200 + r, o_stall, 0);
            @(posedge i_clk);
            #1;
            chk("rf_clr_rs", 200 + r, o_ex_rs_data, 0);
            chk("rf_clr_rt", 200 + r, o_ex_rt_data, 0);
        end

        if (n_cmp < 12) begin
            n_err++;
            $display("FAIL comparison_count: got %0d want >= 12", n_cmp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
